// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel shifter, one log2 stage per cycle (SLL/SRL/SRA/ROTL).
module shift_seq #(
  parameter int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [S-1:0] sa,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] w_q, w_d, z_q, z_d, shl, shr, sra_r, rot, stage;
  logic [S-1:0] sa_q, sa_d, k_q, k_d;
  logic [1:0]   op_q, op_d;
  logic [S:0]   amt;
  always_comb begin
    amt = (S+1)'(1) << k_q;
    shl = w_q << amt;
    shr = w_q >> amt;
    sra_r = $signed(w_q) >>> amt;
    rot = shl | (w_q >> ((S+1)'(N) - amt));
    stage = !sa_q[k_q] ? w_q : op_q == 2'd0 ? shl : op_q == 2'd1 ? shr : op_q == 2'd2 ? sra_r : rot;
  end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    sa_d = sa_q;
    op_d = op_q;
    k_d = k_q;
    z_d = z_q;
    case (state_q)
      IDLE: if (start) begin
        w_d = a;
        sa_d = sa;
        op_d = op;
        k_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        w_d = stage;
        k_d = k_q + 1'b1;
        if (k_q == S'(S-1)) begin
          z_d = stage;
          k_d = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q <= '0;
      sa_q <= '0;
      op_q <= '0;
      k_q <= '0;
      z_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      sa_q <= sa_d;
      op_q <= op_d;
      k_q <= k_d;
      z_q <= z_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign z = z_q;
endmodule
